// File: rtl/dcache_miss_unit.sv
// dcache_miss_unit
//   Initiator side of the dcache <-> mem_ctrl block protocol. Takes one dcache
//   miss at a time, writes back a dirty victim first when needed, then reads
//   the missing block and hands it to the dcache as a one-cycle fill pulse.
// Ports
//   clk, rst_aL                 clock (rising edge), async active-low reset
//   miss_*, victim_*            miss request from the dcache (accepted when miss_valid && miss_ready)
//   miss_ready                  unit idle
//   fill_*                      one-cycle fill pulse with block address and data
//   mem_req_*                   request channel to mem_ctrl (valid/ready handshake)
//   mem_resp_*                  response from mem_ctrl (no back-pressure)
//   miss_count, wb_count        wrapping statistics
//   proto_err                   sticky: response seen while none was outstanding
module dcache_miss_unit #(
    parameter int unsigned BLOCK_ADDR_WIDTH = 26,
    parameter int unsigned BLOCK_DATA_WIDTH = 512,
    parameter int unsigned CNT_WIDTH        = 16
) (
    input  logic                        clk,
    input  logic                        rst_aL,
    input  logic                        miss_valid,
    input  logic [BLOCK_ADDR_WIDTH-1:0] miss_block_addr,
    input  logic                        victim_dirty,
    input  logic [BLOCK_ADDR_WIDTH-1:0] victim_block_addr,
    input  logic [BLOCK_DATA_WIDTH-1:0] victim_block_data,
    output logic                        miss_ready,
    output logic                        fill_valid,
    output logic [BLOCK_ADDR_WIDTH-1:0] fill_block_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] fill_block_data,
    output logic                        mem_req_valid,
    output logic                        mem_req_type,
    output logic [BLOCK_ADDR_WIDTH-1:0] mem_req_block_addr,
    output logic [BLOCK_DATA_WIDTH-1:0] mem_req_block_data,
    input  logic                        mem_req_ready,
    input  logic                        mem_resp_valid,
    input  logic [BLOCK_DATA_WIDTH-1:0] mem_resp_block_data,
    output logic [CNT_WIDTH-1:0]        miss_count,
    output logic [CNT_WIDTH-1:0]        wb_count,
    output logic                        proto_err
);

    localparam int unsigned BAW = BLOCK_ADDR_WIDTH;
    localparam int unsigned BDW = BLOCK_DATA_WIDTH;
    localparam int unsigned CW  = CNT_WIDTH;

    typedef enum logic [2:0] {
        IDLE    = 3'd0,
        WB_REQ  = 3'd1,
        WB_WAIT = 3'd2,
        RD_REQ  = 3'd3,
        RD_WAIT = 3'd4,
        FILL    = 3'd5
    } state_t;

    state_t         state, state_d;
    logic [BAW-1:0] miss_addr_q, miss_addr_d;
    logic [BAW-1:0] victim_addr_q, victim_addr_d;
    logic [BDW-1:0] victim_data_q, victim_data_d;
    logic           miss_inc, wb_inc, resp_expected;

    logic           miss_ready_d, fill_valid_d, mem_req_valid_d, mem_req_type_d, proto_err_d;
    logic [BAW-1:0] fill_block_addr_d, mem_req_block_addr_d;
    logic [BDW-1:0] fill_block_data_d, mem_req_block_data_d;

    // Next-state, latches and next registered outputs
    always_comb begin
        state_d       = state;
        miss_addr_d   = miss_addr_q;
        victim_addr_d = victim_addr_q;
        victim_data_d = victim_data_q;
        miss_inc      = 1'b0;
        wb_inc        = 1'b0;
        resp_expected = 1'b0;

        case (state)
            IDLE: begin
                if (miss_valid) begin
                    miss_addr_d   = miss_block_addr;
                    victim_addr_d = victim_block_addr;
                    victim_data_d = victim_block_data;
                    miss_inc      = 1'b1;
                    state_d       = victim_dirty ? WB_REQ : RD_REQ;
                end
            end
            WB_REQ: begin
                if (mem_req_ready) state_d = WB_WAIT;
            end
            WB_WAIT: begin
                resp_expected = 1'b1;
                if (mem_resp_valid) begin
                    wb_inc  = 1'b1;
                    state_d = RD_REQ;
                end
            end
            RD_REQ: begin
                if (mem_req_ready) state_d = RD_WAIT;
            end
            RD_WAIT: begin
                resp_expected = 1'b1;
                if (mem_resp_valid) state_d = FILL;
            end
            FILL: begin
                state_d = IDLE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase

        // Outputs are a function of the next state so they come straight out of flops
        miss_ready_d         = (state_d == IDLE);
        mem_req_valid_d      = (state_d == WB_REQ) || (state_d == RD_REQ);
        mem_req_type_d       = (state_d == WB_REQ);
        mem_req_block_addr_d = '0;
        mem_req_block_data_d = '0;
        if (state_d == WB_REQ) begin
            mem_req_block_addr_d = victim_addr_d;
            mem_req_block_data_d = victim_data_d;
        end else if (state_d == RD_REQ) begin
            mem_req_block_addr_d = miss_addr_d;
        end
        // FILL is only entered from RD_WAIT on a response, so the response data is live here
        fill_valid_d      = (state_d == FILL);
        fill_block_addr_d = (state_d == FILL) ? miss_addr_q : '0;
        fill_block_data_d = (state_d == FILL) ? mem_resp_block_data : '0;
        proto_err_d       = proto_err | (mem_resp_valid & ~resp_expected);
    end

    // State, latches and registered outputs
    always_ff @(posedge clk or negedge rst_aL) begin
        if (!rst_aL) begin
            state              <= IDLE;
            miss_addr_q        <= '0;
            victim_addr_q      <= '0;
            victim_data_q      <= '0;
            miss_ready         <= 1'b1;
            fill_valid         <= 1'b0;
            fill_block_addr    <= '0;
            fill_block_data    <= '0;
            mem_req_valid      <= 1'b0;
            mem_req_type       <= 1'b0;
            mem_req_block_addr <= '0;
            mem_req_block_data <= '0;
            miss_count         <= '0;
            wb_count           <= '0;
            proto_err          <= 1'b0;
        end else begin
            state              <= state_d;
            miss_addr_q        <= miss_addr_d;
            victim_addr_q      <= victim_addr_d;
            victim_data_q      <= victim_data_d;
            miss_ready         <= miss_ready_d;
            fill_valid         <= fill_valid_d;
            fill_block_addr    <= fill_block_addr_d;
            fill_block_data    <= fill_block_data_d;
            mem_req_valid      <= mem_req_valid_d;
            mem_req_type       <= mem_req_type_d;
            mem_req_block_addr <= mem_req_block_addr_d;
            mem_req_block_data <= mem_req_block_data_d;
            proto_err          <= proto_err_d;
            if (miss_inc) miss_count <= miss_count + CW'(1);
            if (wb_inc)   wb_count   <= wb_count + CW'(1);
        end
    end

endmodule

// File: tb/tb_dcache_miss_unit.sv
// Scoreboard bench for dcache_miss_unit: expected requests and fills are queued
// when a miss is driven and popped as handshakes/fills appear on the DUT ports.
module tb_dcache_miss_unit;

    localparam int BAW = 26;
    localparam int BDW = 512;
    localparam int CW  = 8;
    localparam int N_B2B = 257;

    typedef struct packed {
        logic           typ;
        logic [BAW-1:0] addr;
        logic [BDW-1:0] data;
    } req_t;

    typedef struct packed {
        logic [BAW-1:0] addr;
        logic [BDW-1:0] data;
    } fill_t;

    logic           clk;
    logic           rst_aL;
    logic           miss_valid;
    logic [BAW-1:0] miss_block_addr;
    logic           victim_dirty;
    logic [BAW-1:0] victim_block_addr;
    logic [BDW-1:0] victim_block_data;
    logic           miss_ready;
    logic           fill_valid;
    logic [BAW-1:0] fill_block_addr;
    logic [BDW-1:0] fill_block_data;
    logic           mem_req_valid;
    logic           mem_req_type;
    logic [BAW-1:0] mem_req_block_addr;
    logic [BDW-1:0] mem_req_block_data;
    logic           mem_req_ready;
    logic           mem_resp_valid;
    logic [BDW-1:0] mem_resp_block_data;
    logic [CW-1:0]  miss_count;
    logic [CW-1:0]  wb_count;
    logic           proto_err;

    int      n_checks = 0;
    int      n_errors = 0;
    int      accepts  = 0;
    int      fills    = 0;
    logic [CW-1:0] exp_miss = '0;
    logic [CW-1:0] exp_wb   = '0;
    req_t    req_q[$];
    fill_t   fill_q[$];

    dcache_miss_unit #(
        .BLOCK_ADDR_WIDTH(BAW),
        .BLOCK_DATA_WIDTH(BDW),
        .CNT_WIDTH(CW)
    ) dut (
        .clk(clk),
        .rst_aL(rst_aL),
        .miss_valid(miss_valid),
        .miss_block_addr(miss_block_addr),
        .victim_dirty(victim_dirty),
        .victim_block_addr(victim_block_addr),
        .victim_block_data(victim_block_data),
        .miss_ready(miss_ready),
        .fill_valid(fill_valid),
        .fill_block_addr(fill_block_addr),
        .fill_block_data(fill_block_data),
        .mem_req_valid(mem_req_valid),
        .mem_req_type(mem_req_type),
        .mem_req_block_addr(mem_req_block_addr),
        .mem_req_block_data(mem_req_block_data),
        .mem_req_ready(mem_req_ready),
        .mem_resp_valid(mem_resp_valid),
        .mem_resp_block_data(mem_resp_block_data),
        .miss_count(miss_count),
        .wb_count(wb_count),
        .proto_err(proto_err)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [BDW-1:0] got, input logic [BDW-1:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_errors++;
            $display("FAIL %s got %h exp %h", tag, got, exp);
        end
    endtask

    // Scoreboard side: inputs are final for the coming posedge, outputs stable since the last one
    task automatic monitor();
        req_t  r;
        fill_t f;
        if (miss_valid && miss_ready) begin
            check("accept_outstanding", BDW'(accepts - fills), BDW'(0));
            accepts++;
        end
        if (mem_req_valid && mem_req_ready) begin
            if (req_q.size() == 0) begin
                check("req_unexpected", BDW'(mem_req_valid & mem_req_ready), BDW'(0));
            end else begin
                r = req_q.pop_front();
                check("req_type", BDW'(mem_req_type), BDW'(r.typ));
                check("req_addr", BDW'(mem_req_block_addr), BDW'(r.addr));
                check("req_data", mem_req_block_data, r.data);
            end
        end
        if (fill_valid) begin
            if (fill_q.size() == 0) begin
                check("fill_unexpected", BDW'(fill_valid), BDW'(0));
            end else begin
                f = fill_q.pop_front();
                check("fill_addr", BDW'(fill_block_addr), BDW'(f.addr));
                check("fill_data", fill_block_data, f.data);
            end
            fills++;
        end
    endtask

    // One clock: observe this cycle, then advance to the next falling edge
    task automatic tick();
        monitor();
        @(negedge clk);
    endtask

    task automatic clear_inputs();
        miss_valid          = 1'b0;
        miss_block_addr     = '0;
        victim_dirty        = 1'b0;
        victim_block_addr   = '0;
        victim_block_data   = '0;
        mem_req_ready       = 1'b0;
        mem_resp_valid      = 1'b0;
        mem_resp_block_data = '0;
    endtask

    task automatic do_reset();
        clear_inputs();
        rst_aL = 1'b0;
        #1;
        @(negedge clk);
        rst_aL = 1'b1;
        fills    = accepts;
        exp_miss = '0;
        exp_wb   = '0;
        req_q.delete();
        fill_q.delete();
    endtask

    // Serve one request: optional stall with stability checks, handshake, response after lat cycles
    task automatic serve(input logic typ, input logic [BAW-1:0] addr, input logic [BDW-1:0] data,
                         input int stall, input bit spurious, input int lat, input logic [BDW-1:0] rdata);
        for (int i = 0; i < 20 && !mem_req_valid; i++) tick();
        check("req_valid", BDW'(mem_req_valid), BDW'(1));
        for (int s = 0; s < stall; s++) begin
            check("stall_valid", BDW'(mem_req_valid), BDW'(1));
            check("stall_type", BDW'(mem_req_type), BDW'(typ));
            check("stall_addr", BDW'(mem_req_block_addr), BDW'(addr));
            check("stall_data", mem_req_block_data, data);
            check("stall_miss_ready", BDW'(miss_ready), BDW'(0));
            if (spurious && s == 1) mem_resp_valid = 1'b1;
            tick();
            mem_resp_valid = 1'b0;
            if (spurious && s == 1) check("proto_err_set", BDW'(proto_err), BDW'(1));
        end
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        check("req_dropped", BDW'(mem_req_valid), BDW'(0));
        for (int i = 1; i < lat; i++) begin
            check("wait_no_req", BDW'(mem_req_valid), BDW'(0));
            check("wait_no_fill", BDW'(fill_valid), BDW'(0));
            tick();
        end
        mem_resp_valid      = 1'b1;
        mem_resp_block_data = rdata;
        tick();
        mem_resp_valid      = 1'b0;
        mem_resp_block_data = '0;
        if (typ) begin
            exp_wb++;
            check("wb_then_rd", BDW'(mem_req_valid), BDW'(1));
            check("wb_then_rd_type", BDW'(mem_req_type), BDW'(0));
        end else begin
            check("fill_latency", BDW'(fill_valid), BDW'(1));
        end
    endtask

    task automatic do_miss(input logic [BAW-1:0] addr, input logic dirty, input logic [BAW-1:0] vaddr,
                           input logic [BDW-1:0] vdata, input int stall, input bit spurious,
                           input logic [BDW-1:0] rdata);
        if (dirty) req_q.push_back('{1'b1, vaddr, vdata});
        req_q.push_back('{1'b0, addr, {BDW{1'b0}}});
        fill_q.push_back('{addr, rdata});
        for (int i = 0; i < 20 && !miss_ready; i++) tick();
        check("miss_ready_idle", BDW'(miss_ready), BDW'(1));
        miss_valid        = 1'b1;
        miss_block_addr   = addr;
        victim_dirty      = dirty;
        victim_block_addr = vaddr;
        victim_block_data = vdata;
        tick();
        miss_valid        = 1'b0;
        miss_block_addr   = BAW'($urandom());
        victim_dirty      = 1'b1;
        victim_block_addr = BAW'($urandom());
        victim_block_data = {16{$urandom()}};
        exp_miss++;
        check("miss_ready_busy", BDW'(miss_ready), BDW'(0));
        check("req_next_cycle", BDW'(mem_req_valid), BDW'(1));
        check("miss_count", BDW'(miss_count), BDW'(exp_miss));
        if (dirty) serve(1'b1, vaddr, vdata, stall, 1'b0, 2, {16{$urandom()}});
        serve(1'b0, addr, '0, stall, spurious, 3, rdata);
        tick();
        check("idle_after_fill", BDW'(miss_ready), BDW'(1));
        check("fill_one_cycle", BDW'(fill_valid), BDW'(0));
        check("wb_count", BDW'(wb_count), BDW'(exp_wb));
    endtask

    initial begin
        logic [BDW-1:0] rd;
        logic [BAW-1:0] a;

        clear_inputs();
        rst_aL = 1'b0;
        repeat (2) @(negedge clk);
        check("rst_miss_ready", BDW'(miss_ready), BDW'(1));
        check("rst_req_valid", BDW'(mem_req_valid), BDW'(0));
        check("rst_fill_valid", BDW'(fill_valid), BDW'(0));
        check("rst_miss_count", BDW'(miss_count), BDW'(0));
        check("rst_proto_err", BDW'(proto_err), BDW'(0));
        rst_aL = 1'b1;
        tick();

        // Clean miss
        do_miss(BAW'(26'h10), 1'b0, BAW'($urandom()), {16{$urandom()}}, 0, 1'b0, {64{8'hA5}});
        check("t1_miss_count", BDW'(miss_count), BDW'(1));
        check("t1_wb_count", BDW'(wb_count), BDW'(0));

        // Dirty miss: writeback precedes read
        do_miss(BAW'(26'h30), 1'b1, BAW'(26'h20), {64{8'h5A}}, 0, 1'b0, {16{$urandom()}});
        check("t2_wb_count", BDW'(wb_count), BDW'(1));

        // Back-pressure on both requests
        do_miss(BAW'($urandom()), 1'b1, BAW'($urandom()), {16{$urandom()}}, 5, 1'b0, {16{$urandom()}});
        check("t3_no_proto_err", BDW'(proto_err), BDW'(0));

        // Spurious responses in IDLE and RD_REQ
        mem_resp_valid = 1'b1;
        tick();
        mem_resp_valid = 1'b0;
        check("t4_proto_err_idle", BDW'(proto_err), BDW'(1));
        check("t4_still_idle", BDW'(miss_ready), BDW'(1));
        check("t4_no_fill", BDW'(fill_valid), BDW'(0));
        tick();
        check("t4_sticky", BDW'(proto_err), BDW'(1));
        do_miss(BAW'($urandom()), 1'b0, BAW'($urandom()), {16{$urandom()}}, 3, 1'b1, {16{$urandom()}});
        check("t4_sticky_end", BDW'(proto_err), BDW'(1));

        // Reset while waiting for read data
        a = BAW'($urandom());
        req_q.push_back('{1'b0, a, {BDW{1'b0}}});
        miss_valid      = 1'b1;
        miss_block_addr = a;
        victim_dirty    = 1'b0;
        tick();
        miss_valid    = 1'b0;
        mem_req_ready = 1'b1;
        tick();
        mem_req_ready = 1'b0;
        rst_aL = 1'b0;
        #1;
        check("t5_miss_ready", BDW'(miss_ready), BDW'(1));
        check("t5_req_valid", BDW'(mem_req_valid), BDW'(0));
        check("t5_req_addr", BDW'(mem_req_block_addr), BDW'(0));
        check("t5_fill_valid", BDW'(fill_valid), BDW'(0));
        check("t5_miss_count", BDW'(miss_count), BDW'(0));
        check("t5_proto_err", BDW'(proto_err), BDW'(0));
        @(negedge clk);
        rst_aL   = 1'b1;
        fills    = accepts;
        exp_miss = '0;
        exp_wb   = '0;
        repeat (3) tick();
        do_miss(BAW'($urandom()), 1'b1, BAW'($urandom()), {16{$urandom()}}, 1, 1'b0, {16{$urandom()}});
        check("t5_after_reset_count", BDW'(miss_count), BDW'(1));

        // Back-to-back clean misses with miss_valid held; counter wraps
        do_reset();
        miss_valid   = 1'b1;
        victim_dirty = 1'b0;
        for (int n = 0; n < N_B2B; n++) begin
            for (int i = 0; i < 20 && !miss_ready; i++) tick();
            check("b2b_ready", BDW'(miss_ready), BDW'(1));
            a  = BAW'($urandom());
            rd = {16{$urandom()}};
            miss_block_addr = a;
            req_q.push_back('{1'b0, a, {BDW{1'b0}}});
            fill_q.push_back('{a, rd});
            tick();
            check("b2b_req", BDW'(mem_req_valid), BDW'(1));
            mem_req_ready = 1'b1;
            tick();
            mem_req_ready       = 1'b0;
            mem_resp_valid      = 1'b1;
            mem_resp_block_data = rd;
            tick();
            mem_resp_valid      = 1'b0;
            mem_resp_block_data = '0;
            check("b2b_fill", BDW'(fill_valid), BDW'(1));
            tick();
        end
        miss_valid = 1'b0;
        repeat (2) tick();
        check("b2b_miss_count_wrap", BDW'(miss_count), BDW'(N_B2B % (1 << CW)));
        check("b2b_wb_count", BDW'(wb_count), BDW'(0));
        check("b2b_fills", BDW'(fills - accepts), BDW'(0));
        check("b2b_req_q_empty", BDW'(req_q.size()), BDW'(0));
        check("b2b_fill_q_empty", BDW'(fill_q.size()), BDW'(0));

        $display("CHECKS %0d ERRORS %0d", n_checks, n_errors);
        $finish;
    end

endmodule
